ov7670_rgb565_capture: RTL and testbench

- Upstream stage of the per-channel colour filter in the HexImageFilter pipeline.
- Samples the OV7670 parallel bus (PCLK, VSYNC, HREF, D[7:0]) in the system clock domain and assembles byte pairs into RGB565 pixels.
- Expands each pixel to 8 bits per channel and presents it on data_w_R/G/B with a one-cycle valid strobe and x/y coordinates.
- Downstream frame-buffer write logic uses the coordinates to address memory.

---
 rtl/ov7670_rgb565_capture.sv | 246 ++++++++++++++++++++++++
 tb/tb_ov7670_rgb565_capture.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_rgb565_capture.sv
// OV7670 parallel-bus capture: synchronises the camera strobes into clk,
// pairs bytes into RGB565 pixels, expands them to 8 bits per channel and
// emits one strobe per pixel with x/y coordinates.
// Optional build macro CAPTURE_TEST_PATTERN_EN adds a test_mode input.
// When test_mode is high, the pixel data is replaced by 8 vertical colour bars.
//
// state       | meaning
// ------------+-------------------------------------------------------
// WAIT_FRAME  | idle until VSYNC falls (start of a new frame)
// WAIT_LINE   | inside a frame, waiting for the first byte of a line
// BYTE_LO     | high byte latched, next pclk edge completes the pixel
// BYTE_HI     | pixel complete, next pclk edge is a new high byte
module ov7670_rgb565_capture #(
  parameter int H_PIX   = 160,
  parameter int V_LINES = 120,
  parameter int XW      = 8,
  parameter int YW      = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cam_pclk,
  input  logic          cam_vsync,
  input  logic          cam_href,
  input  logic [7:0]    cam_data,
  output logic [7:0]    data_w_R,
  output logic [7:0]    data_w_G,
  output logic [7:0]    data_w_B,
  output logic          pix_valid,
  output logic [XW-1:0] pix_x,
  output logic [YW-1:0] pix_y,
  output logic          line_done,
  output logic          frame_done,
  output logic          odd_byte_err
`ifdef CAPTURE_TEST_PATTERN_EN
  ,
  input  logic          test_mode
`endif
);

  typedef enum logic [1:0] {
    S_WAIT_FRAME,
    S_WAIT_LINE,
    S_BYTE_LO,
    S_BYTE_HI
  } state_e;

  // Counters are one bit wider than the coordinates so they can park at
  // H_PIX / V_LINES even when those equal 2^XW / 2^YW.
  localparam logic [XW:0] H_MAX = (XW+1)'(H_PIX);
  localparam logic [YW:0] V_MAX = (YW+1)'(V_LINES);

  logic       pclk_s1_q, pclk_s2_q, pclk_prev_q;
  logic       vsync_s1_q, vsync_s2_q, vsync_prev_q;
  logic       href_s1_q, href_s2_q, href_prev_q;
  logic [7:0] data_s1_q, data_s2_q;

  state_e      state_q, state_d;
  logic [7:0]  hi_q, hi_d;
  logic [XW:0] x_cnt_q, x_cnt_d;
  logic [YW:0] y_cnt_q, y_cnt_d;
  logic [7:0]  r_q, r_d, g_q, g_d, b_q, b_d;
  logic        valid_q, valid_d;
  logic [XW-1:0] px_q, px_d;
  logic [YW-1:0] py_q, py_d;
  logic        line_done_q, line_done_d;
  logic        frame_done_q, frame_done_d;
  logic        odd_err_q, odd_err_d;

  logic        pclk_rise, vsync_rise, vsync_fall, href_fall;
  logic [15:0] pixel;
  logic [7:0]  exp_r, exp_g, exp_b;
  logic        in_window;
  logic [XW:0] x_next;
  logic [YW:0] y_next;

  // Two-flop synchronisers plus one history flop for edge detection.
  // Data shares the stage with pclk so it lines up with the detected edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pclk_s1_q    <= 1'b0;
      pclk_s2_q    <= 1'b0;
      pclk_prev_q  <= 1'b0;
      vsync_s1_q   <= 1'b0;
      vsync_s2_q   <= 1'b0;
      vsync_prev_q <= 1'b0;
      href_s1_q    <= 1'b0;
      href_s2_q    <= 1'b0;
      href_prev_q  <= 1'b0;
      data_s1_q    <= 8'h00;
      data_s2_q    <= 8'h00;
    end else begin
      pclk_s1_q    <= cam_pclk;
      pclk_s2_q    <= pclk_s1_q;
      pclk_prev_q  <= pclk_s2_q;
      vsync_s1_q   <= cam_vsync;
      vsync_s2_q   <= vsync_s1_q;
      vsync_prev_q <= vsync_s2_q;
      href_s1_q    <= cam_href;
      href_s2_q    <= href_s1_q;
      href_prev_q  <= href_s2_q;
      data_s1_q    <= cam_data;
      data_s2_q    <= data_s1_q;
    end
  end

  assign pclk_rise  = pclk_s2_q & ~pclk_prev_q;
  assign vsync_rise = vsync_s2_q & ~vsync_prev_q;
  assign vsync_fall = ~vsync_s2_q & vsync_prev_q;
  assign href_fall  = ~href_s2_q & href_prev_q;

  assign pixel     = {hi_q, data_s2_q};
  assign in_window = (x_cnt_q < H_MAX) && (y_cnt_q < V_MAX);
  assign x_next    = (x_cnt_q == H_MAX) ? x_cnt_q : x_cnt_q + 1'b1;
  assign y_next    = (y_cnt_q == V_MAX) ? y_cnt_q : y_cnt_q + 1'b1;

  // Channel expansion: replicate the top bits into the new LSBs so full
  // scale maps to 0xFF. Test pattern replaces camera data with colour bars.
  always_comb begin
    exp_r = {pixel[15:11], pixel[15:13]};
    exp_g = {pixel[10:5],  pixel[10:9]};
    exp_b = {pixel[4:0],   pixel[4:2]};
`ifdef CAPTURE_TEST_PATTERN_EN
    if (test_mode) begin
      logic [2:0] bar;
      bar   = 3'(({x_cnt_q, 3'b000}) / (XW+4)'(H_PIX));
      exp_r = {8{bar[2]}};
      exp_g = {8{bar[1]}};
      exp_b = {8{bar[0]}};
    end
`endif
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_WAIT_FRAME;
      hi_q         <= 8'h00;
      x_cnt_q      <= '0;
      y_cnt_q      <= '0;
      r_q          <= 8'h00;
      g_q          <= 8'h00;
      b_q          <= 8'h00;
      valid_q      <= 1'b0;
      px_q         <= '0;
      py_q         <= '0;
      line_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      odd_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hi_q         <= hi_d;
      x_cnt_q      <= x_cnt_d;
      y_cnt_q      <= y_cnt_d;
      r_q          <= r_d;
      g_q          <= g_d;
      b_q          <= b_d;
      valid_q      <= valid_d;
      px_q         <= px_d;
      py_q         <= py_d;
      line_done_q  <= line_done_d;
      frame_done_q <= frame_done_d;
      odd_err_q    <= odd_err_d;
    end
  end

  // Next-state logic; VSYNC rise outranks every other event, and an HREF
  // fall outranks a coincident pclk edge.
  always_comb begin
    state_d      = state_q;
    hi_d         = hi_q;
    x_cnt_d      = x_cnt_q;
    y_cnt_d      = y_cnt_q;
    r_d          = r_q;
    g_d          = g_q;
    b_d          = b_q;
    valid_d      = 1'b0;
    px_d         = px_q;
    py_d         = py_q;
    line_done_d  = 1'b0;
    frame_done_d = 1'b0;
    odd_err_d    = odd_err_q;

    if (vsync_rise && (state_q != S_WAIT_FRAME)) begin
      frame_done_d = (y_cnt_q != '0);
      state_d      = S_WAIT_FRAME;
    end else begin
      unique case (state_q)
        S_WAIT_FRAME: begin
          if (vsync_fall) begin
            x_cnt_d = '0;
            y_cnt_d = '0;
            state_d = S_WAIT_LINE;
          end
        end
        S_WAIT_LINE: begin
          if (pclk_rise && href_s2_q) begin
            hi_d    = data_s2_q;
            x_cnt_d = '0;
            state_d = S_BYTE_LO;
          end
        end
        S_BYTE_LO: begin
          if (href_fall) begin
            line_done_d = 1'b1;
            y_cnt_d     = y_next;
            odd_err_d   = 1'b1;
            state_d     = S_WAIT_LINE;
          end else if (pclk_rise && href_s2_q) begin
            if (in_window) begin
              valid_d = 1'b1;
              r_d     = exp_r;
              g_d     = exp_g;
              b_d     = exp_b;
              px_d    = x_cnt_q[XW-1:0];
              py_d    = y_cnt_q[YW-1:0];
            end
            x_cnt_d = x_next;
            state_d = S_BYTE_HI;
          end
        end
        S_BYTE_HI: begin
          if (href_fall) begin
            line_done_d = 1'b1;
            y_cnt_d     = y_next;
            state_d     = S_WAIT_LINE;
          end else if (pclk_rise && href_s2_q) begin
            hi_d    = data_s2_q;
            state_d = S_BYTE_LO;
          end
        end
        default: state_d = S_WAIT_FRAME;
      endcase
    end
  end

  assign data_w_R     = r_q;
  assign data_w_G     = g_q;
  assign data_w_B     = b_q;
  assign pix_valid    = valid_q;
  assign pix_x        = px_q;
  assign pix_y        = py_q;
  assign line_done    = line_done_q;
  assign frame_done   = frame_done_q;
  assign odd_byte_err = odd_err_q;

endmodule

// File: tb/tb_ov7670_rgb565_capture.sv
// Directed bench for ov7670_rgb565_capture: drives a slow camera bus
// (pclk = 8 clk periods) and checks captured pixels and status strobes.
module tb_ov7670_rgb565_capture;

  localparam int H_PIX = 160;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cam_pclk, cam_vsync, cam_href;
  logic [7:0] cam_data;
  logic [7:0] data_w_R, data_w_G, data_w_B;
  logic       pix_valid;
  logic [7:0] pix_x;
  logic [6:0] pix_y;
  logic       line_done, frame_done, odd_byte_err;
`ifdef CAPTURE_TEST_PATTERN_EN
  logic       test_mode = 1'b0;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [38:0] pix_q[$];
  int n_line = 0;
  int n_frame = 0;

  always #5 clk = ~clk;

  ov7670_rgb565_capture dut (
    .clk(clk),
    .rst_n(rst_n),
    .cam_pclk(cam_pclk),
    .cam_vsync(cam_vsync),
    .cam_href(cam_href),
    .cam_data(cam_data),
    .data_w_R(data_w_R),
    .data_w_G(data_w_G),
    .data_w_B(data_w_B),
    .pix_valid(pix_valid),
    .pix_x(pix_x),
    .pix_y(pix_y),
    .line_done(line_done),
    .frame_done(frame_done),
    .odd_byte_err(odd_byte_err)
`ifdef CAPTURE_TEST_PATTERN_EN
    ,
    .test_mode(test_mode)
`endif
  );

  // Record every strobe, sampled on the falling edge.
  always @(negedge clk) begin
    if (pix_valid) pix_q.push_back({data_w_R, data_w_G, data_w_B, pix_x, pix_y});
    if (line_done) n_line <= n_line + 1;
    if (frame_done) n_frame <= n_frame + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_pix(input string tag, input int idx, input logic [7:0] r,
                           input logic [7:0] g, input logic [7:0] b,
                           input logic [7:0] x, input logic [6:0] y);
    logic [38:0] obs;
    obs = (idx < pix_q.size()) ? pix_q[idx] : '1;
    check(tag, 64'(obs), 64'({r, g, b, x, y}));
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cam_byte(input logic [7:0] b);
    cam_data = b;
    cam_href = 1'b1;
    wait_clk(4);
    cam_pclk = 1'b1;
    wait_clk(4);
    cam_pclk = 1'b0;
  endtask

  task automatic send_pixel(input logic [15:0] p);
    cam_byte(p[15:8]);
    cam_byte(p[7:0]);
  endtask

  task automatic end_line;
    wait_clk(4);
    cam_href = 1'b0;
    wait_clk(8);
  endtask

  task automatic frame_start;
    cam_vsync = 1'b0;
    wait_clk(8);
  endtask

  task automatic frame_end;
    cam_vsync = 1'b1;
    wait_clk(12);
  endtask

  initial begin
    int p0, l0, f0;
    rst_n     = 1'b0;
    cam_pclk  = 1'b0;
    cam_vsync = 1'b1;
    cam_href  = 1'b0;
    cam_data  = 8'h00;
    wait_clk(5);

    // Reset state
    check("rst_valid", 64'(pix_valid), 64'd0);
    check("rst_rgb", 64'({data_w_R, data_w_G, data_w_B}), 64'd0);
    check("rst_xy", 64'({pix_x, pix_y}), 64'd0);
    check("rst_flags", 64'({line_done, frame_done, odd_byte_err}), 64'd0);
    rst_n = 1'b1;
    wait_clk(10);

    // Frame A: 2 lines x 4 red pixels
    p0 = pix_q.size(); l0 = n_line; f0 = n_frame;
    frame_start;
    for (int ln = 0; ln < 2; ln++) begin
      for (int px = 0; px < 4; px++) send_pixel(16'hF800);
      end_line;
    end
    frame_end;
    check("A_count", 64'(pix_q.size() - p0), 64'd8);
    for (int i = 0; i < 8; i++)
      check_pix("A_pix", p0 + i, 8'hFF, 8'h00, 8'h00, 8'(i % 4), 7'(i / 4));
    check("A_lines", 64'(n_line - l0), 64'd2);
    check("A_frames", 64'(n_frame - f0), 64'd1);
    check("A_odd", 64'(odd_byte_err), 64'd0);

    // Frame B: colour vectors, then a 5-byte line
    p0 = pix_q.size(); l0 = n_line; f0 = n_frame;
    frame_start;
    send_pixel(16'h07E0);
    send_pixel(16'h001F);
    send_pixel(16'h8410);
    end_line;
    check("B_odd_pre", 64'(odd_byte_err), 64'd0);
    cam_byte(8'hFF); cam_byte(8'hFF);
    cam_byte(8'h00); cam_byte(8'h00);
    cam_byte(8'hAA);
    end_line;
    frame_end;
    check("B_count", 64'(pix_q.size() - p0), 64'd5);
    check_pix("B_green", p0 + 0, 8'h00, 8'hFF, 8'h00, 8'd0, 7'd0);
    check_pix("B_blue",  p0 + 1, 8'h00, 8'h00, 8'hFF, 8'd1, 7'd0);
    check_pix("B_grey",  p0 + 2, 8'h84, 8'h82, 8'h84, 8'd2, 7'd0);
    check_pix("B_white", p0 + 3, 8'hFF, 8'hFF, 8'hFF, 8'd0, 7'd1);
    check_pix("B_black", p0 + 4, 8'h00, 8'h00, 8'h00, 8'd1, 7'd1);
    check("B_lines", 64'(n_line - l0), 64'd2);
    check("B_frames", 64'(n_frame - f0), 64'd1);
    check("B_odd", 64'(odd_byte_err), 64'd1);

    // Frame C: line of H_PIX+3 pixels
    p0 = pix_q.size(); l0 = n_line; f0 = n_frame;
    frame_start;
    for (int px = 0; px < H_PIX + 3; px++) send_pixel(16'h0000);
    end_line;
    frame_end;
    check("C_count", 64'(pix_q.size() - p0), 64'(H_PIX));
    check_pix("C_last", p0 + H_PIX - 1, 8'h00, 8'h00, 8'h00, 8'(H_PIX - 1), 7'd0);
    check("C_pix_x", 64'(pix_x), 64'(H_PIX - 1));
    check("C_lines", 64'(n_line - l0), 64'd1);
    check("C_odd_sticky", 64'(odd_byte_err), 64'd1);

    // Frame D: VSYNC rise mid-line 1 at x = 2
    p0 = pix_q.size(); l0 = n_line; f0 = n_frame;
    frame_start;
    send_pixel(16'hF800); send_pixel(16'hF800);
    end_line;
    send_pixel(16'h07E0); send_pixel(16'h07E0);
    cam_byte(8'h00);
    cam_vsync = 1'b1;
    wait_clk(10);
    cam_byte(8'h12); cam_byte(8'h34);
    cam_href = 1'b0;
    wait_clk(8);
    check("D_count", 64'(pix_q.size() - p0), 64'd4);
    check_pix("D_last", p0 + 3, 8'h00, 8'hFF, 8'h00, 8'd1, 7'd1);
    check("D_lines", 64'(n_line - l0), 64'd1);
    check("D_frames", 64'(n_frame - f0), 64'd1);

    // Frame E: restarts at x = 0, y = 0
    p0 = pix_q.size(); f0 = n_frame;
    frame_start;
    send_pixel(16'h001F);
    end_line;
    frame_end;
    check("E_count", 64'(pix_q.size() - p0), 64'd1);
    check_pix("E_pix", p0, 8'h00, 8'h00, 8'hFF, 8'd0, 7'd0);
    check("E_frames", 64'(n_frame - f0), 64'd1);

    // Frame F: reset after a high byte
    p0 = pix_q.size(); l0 = n_line; f0 = n_frame;
    frame_start;
    cam_byte(8'hF8);
    rst_n = 1'b0;
    wait_clk(1);
    check("F_rst_valid", 64'(pix_valid), 64'd0);
    check("F_rst_rgb", 64'({data_w_R, data_w_G, data_w_B}), 64'd0);
    check("F_rst_xy", 64'({pix_x, pix_y}), 64'd0);
    check("F_rst_flags", 64'({line_done, frame_done, odd_byte_err}), 64'd0);
    rst_n = 1'b1;
    cam_byte(8'h00);
    send_pixel(16'hF800);
    end_line;
    frame_end;
    check("F_no_strobe", 64'(pix_q.size() - p0), 64'd0);
    check("F_no_line", 64'(n_line - l0), 64'd0);
    check("F_no_frame", 64'(n_frame - f0), 64'd0);
    frame_start;
    send_pixel(16'h07E0);
    end_line;
    frame_end;
    check("F_resume_count", 64'(pix_q.size() - p0), 64'd1);
    check_pix("F_resume_pix", p0, 8'h00, 8'hFF, 8'h00, 8'd0, 7'd0);
    check("F_resume_frame", 64'(n_frame - f0), 64'd1);
    check("F_odd_clear", 64'(odd_byte_err), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
